spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- Synthesizable SPI target that models one converter chip's control port on the shared converter SPI bus.
- Used in cosim and on test fixtures. It lets the converter SPI controller program and read back registers without real DAC/ADC silicon.
- Supports TI format (R/W flag in address MSB, 2 bytes per frame) and ADI format (global-address byte with R/W flag in LSB, 3 bytes per frame).
- Holds a local register file and reports every completed write to the fabric.

Parameters:
- FORMAT, 1, frame format: 1 = TI, 2 = ADI; any other value = unresponsive (never drives MDO, never writes).
- GLOBAL_ADDR, 7'h04, ADI chip address matched against global byte bits [7:1].
- REG_ADDR_BITS, 6, register file holds 2^REG_ADDR_BITS 8-bit registers.

Ports:
- clk  in  1  system clock; all logic runs on it; must be ≥8× spi_mclk.
- reset  in  1  asynchronous, active-low reset.
- spi_mclk  in  1  SPI clock from controller; asynchronous to clk.
- spi_cs  in  1  chip select, active-high.
- spi_mdi  in  1  controller-to-target data.
- spi_mdo  out  1  target-to-controller data.
- spi_mdo_oe  out  1  MDO drive enable; top level tristates MDO when low.
- reg_wr_strobe  out  1  one-clk pulse when a register write commits.
- reg_wr_addr  out  8  address of the committed write.
- reg_wr_data  out  8  data of the committed write.
- peek_addr  in  REG_ADDR_BITS  combinational register-file read address for the bench/fabric.
- peek_data  out  8  register-file contents at peek_addr.
- frame_error  out  1  one-clk pulse when a frame aborts (CS drops mid-frame) or the ADI global address mismatches.

Behaviour:
- Input synchronization:
  - spi_mclk, spi_cs and spi_mdi each pass through a 2-flop synchronizer.
  - A third flop on mclk and cs provides edge detection.
- Bit timing:
  - The controller changes MDI on rising mclk; each bit is valid for one full mclk period.
  - MDI is sampled on the detected falling mclk edge while synced CS = 1, MSB first.
- Reset (reset = 0):
  - state = IDLE; spi_mdo = 0, spi_mdo_oe = 0.
  - reg_wr_strobe = 0, reg_wr_addr = 0, reg_wr_data = 0, frame_error = 0.
  - bit counter = 0; all registers = 8'h00.
  - Reset mid-frame discards the frame; no write occurs.
- States:
  - IDLE → GLOBAL (FORMAT=2) or ADDR (FORMAT=1) on CS rising edge, with bit counter cleared.
  - IDLE → IGNORE on CS rising edge for any other FORMAT.
  - GLOBAL: shift 8 bits.
    - If byte[7:1] == GLOBAL_ADDR: latch rw = byte[0] (1 = write), go to ADDR.
    - Otherwise: pulse frame_error, go to IGNORE.
  - ADDR: shift 8 bits.
    - TI: rw = ~byte[7] (0 = write); register address = byte[5:0]; byte[6] is ignored.
    - ADI: register address = full byte.
    - Go to DATA.
  - DATA, write: shift 8 bits. After the 8th sample, if the address is in range (address < 2^REG_ADDR_BITS):
    - store the byte in the register file;
    - assert reg_wr_strobe for exactly 1 clk, with reg_wr_addr/reg_wr_data valid in the same cycle;
    - then go to DONE.
  - DATA, read:
    - Within 4 clk of the falling edge that samples the final address bit, assert spi_mdo_oe = 1 and drive spi_mdo = reg[7].
    - On each following falling edge (7 of them), drive the next lower bit.
    - After the 8th data-period falling edge, go to DONE.
    - Out-of-range read returns 8'h00.
  - DONE / IGNORE: spi_mdo_oe = 0; wait for CS falling edge, then → IDLE.
- CS falling edge in GLOBAL/ADDR/DATA (partial frame):
  - pulse frame_error; discard shifted bits; no write; → IDLE; oe = 0 within 1 clk.
- CS rising edge while not IDLE: treated as abort followed by new frame start.
- Extra mclk edges in DONE/IGNORE are ignored.
- spi_mdo_oe is only ever 1 in DATA read with synced CS = 1.
- peek_data is combinational. A write commit is visible on peek_data the cycle after the strobe.

Decomposition:
- Shared package spi_defs:
  - SPI_FORMAT_NONE/TI/ADI codes (0/1/2);
  - ADI default global address 7'h04;
  - TI R/W bit position and polarity.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall detect. Instantiated for mclk and cs; mdi uses the synchronizer only.

Test Plan:
- TI write, FORMAT=1: bytes 0x15, 0xA5 → one reg_wr_strobe with addr 0x15 / data 0xA5; peek_addr=0x15 → peek_data 0xA5; spi_mdo_oe stays 0.
- TI read after the write: bytes 0x95, 8 dummy data clocks → controller captures 0xA5; oe high only during the data byte; no strobe.
- ADI write then read, FORMAT=2, GLOBAL_ADDR=0x04:
  - write frame 0x09, 0x21, 0x3C → reg[0x21] = 0x3C;
  - read frame 0x08, 0x21 → MDO shifts 0x3C.
- ADI mismatch: global byte 0x0B, 0x21, 0xFF → frame_error pulse; reg[0x21] unchanged; oe never asserted.
- Abort: TI write CS dropped after 11 bits → frame_error pulse, no strobe; next full frame 0x02, 0x7E writes reg[2] = 0x7E.
- Reset mid-frame: reset low during data byte of a write to 0x03 → no strobe; all peeks read 0x00; next frame decodes normally.

Source files
------------

// File: rtl/spi_responder_pkg.sv
// Shared definitions for the converter SPI responder: frame format codes,
// ADI default chip address, TI R/W flag placement and the FSM state type.
package spi_defs;

  localparam int SPI_FORMAT_NONE = 0;
  localparam int SPI_FORMAT_TI   = 1;
  localparam int SPI_FORMAT_ADI  = 2;

  // ADI chip address compared against global byte bits [7:1]
  localparam logic [6:0] ADI_GLOBAL_ADDR_DEFAULT = 7'h04;

  // TI frames carry the R/W flag in the address MSB; a 1 there means read
  localparam int   TI_RW_BIT  = 7;
  localparam logic TI_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GLOBAL = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_IGNORE = 3'd5
  } spi_state_e;

  // True when an 8-bit register address falls inside a 2^bits register file
  function automatic logic addr_in_range(input logic [7:0] addr, input int bits);
    if (bits >= 8) begin
      return 1'b1;
    end else begin
      return (addr >> bits) == 8'h00;
    end
  endfunction

endpackage

// File: rtl/spi_responder_if.sv
// Converter SPI bus as seen by one target: controller drives clock, select
// and MDI; the target drives MDO together with its tristate enable.
interface spi_responder_if;
  logic spi_mclk;
  logic spi_cs;
  logic spi_mdi;
  logic spi_mdo;
  logic spi_mdo_oe;

  modport master (
    output spi_mclk, spi_cs, spi_mdi,
    input  spi_mdo, spi_mdo_oe
  );

  modport slave (
    input  spi_mclk, spi_cs, spi_mdi,
    output spi_mdo, spi_mdo_oe
  );
endinterface

// File: rtl/spi_responder_sync_edge.sv
// Brings one asynchronous SPI line into the clk domain through two flops and
// keeps a third delayed copy so single-cycle rise/fall pulses can be formed.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Shift the raw line through the synchronizer and edge-detect stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_responder.sv
// SPI target standing in for one converter's control port. Decodes TI
// (2-byte) or ADI (3-byte, global address first) frames, keeps a local
// register file, shifts read data out on MDO and reports committed writes.
module spi_responder
  import spi_defs::*;
#(
  parameter int         FORMAT        = SPI_FORMAT_TI,
  parameter logic [6:0] GLOBAL_ADDR   = ADI_GLOBAL_ADDR_DEFAULT,
  parameter int         REG_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_responder_if.slave           spi,
  output logic                     reg_wr_strobe,
  output logic [7:0]               reg_wr_addr,
  output logic [7:0]               reg_wr_data,
  input  logic [REG_ADDR_BITS-1:0] peek_addr,
  output logic [7:0]               peek_data,
  output logic                     frame_error
);

  localparam int NUM_REGS = 1 << REG_ADDR_BITS;

  // Synchronized bus lines and edge pulses
  logic cs_s, cs_rise_s, cs_fall_s, mclk_fall_s, mdi_s;
  logic unused_mclk_sync_s, unused_mclk_rise_s;
  logic [1:0] mdi_sync_q;

  spi_sync_edge u_mclk_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (spi.spi_mclk),
    .sync_o  (unused_mclk_sync_s),
    .rise_o  (unused_mclk_rise_s),
    .fall_o  (mclk_fall_s)
  );

  spi_sync_edge u_cs_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (spi.spi_cs),
    .sync_o  (cs_s),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  // MDI needs only the two-flop synchronizer; it lines up with synced mclk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdi_sync_q <= 2'b00;
    end else begin
      mdi_sync_q <= {mdi_sync_q[0], spi.spi_mdi};
    end
  end
  assign mdi_s = mdi_sync_q[1];

  // Frame state and registered outputs
  spi_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [6:0] rd_shift_q;
  logic [7:0] addr_q;
  logic       rw_q;           // 1 = write
  logic       mdo_q, oe_q;
  logic       reg_wr_strobe_q, frame_error_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [7:0] regs_q [NUM_REGS];

  // Byte being completed by the current sample and its decoded meaning
  logic [7:0] shift_d;
  logic [7:0] addr_d;
  logic [7:0] rd_byte_d;
  logic       ti_write_s;
  logic       wr_flag_d;
  logic       in_frame_s;

  assign shift_d    = {shift_q, mdi_s};
  assign addr_d     = (FORMAT == SPI_FORMAT_TI) ? {2'b00, shift_d[5:0]} : shift_d;
  assign ti_write_s = (shift_d[TI_RW_BIT] != TI_RW_READ);
  assign wr_flag_d  = (FORMAT == SPI_FORMAT_TI) ? ti_write_s : rw_q;
  assign rd_byte_d  = addr_in_range(addr_d, REG_ADDR_BITS) ?
                      regs_q[addr_d[REG_ADDR_BITS-1:0]] : 8'h00;
  assign in_frame_s = (state_q == ST_GLOBAL) || (state_q == ST_ADDR) ||
                      (state_q == ST_DATA);

  // Frame sequencer: CS edges take priority over bit sampling on mclk falls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 7'd0;
      rd_shift_q      <= 7'd0;
      addr_q          <= 8'h00;
      rw_q            <= 1'b0;
      mdo_q           <= 1'b0;
      oe_q            <= 1'b0;
      reg_wr_strobe_q <= 1'b0;
      wr_addr_q       <= 8'h00;
      wr_data_q       <= 8'h00;
      frame_error_q   <= 1'b0;
    end else begin
      reg_wr_strobe_q <= 1'b0;
      frame_error_q   <= 1'b0;
      if (cs_rise_s) begin
        // A new select while mid-frame aborts the old frame first
        if (in_frame_s) frame_error_q <= 1'b1;
        bit_cnt_q <= 3'd0;
        shift_q   <= 7'd0;
        mdo_q     <= 1'b0;
        oe_q      <= 1'b0;
        if (FORMAT == SPI_FORMAT_TI) begin
          state_q <= ST_ADDR;
        end else if (FORMAT == SPI_FORMAT_ADI) begin
          state_q <= ST_GLOBAL;
        end else begin
          state_q <= ST_IGNORE;
        end
      end else if (cs_fall_s) begin
        if (in_frame_s) frame_error_q <= 1'b1;
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        mdo_q     <= 1'b0;
        oe_q      <= 1'b0;
      end else if (mclk_fall_s && cs_s) begin
        case (state_q)
          ST_GLOBAL: begin
            shift_q   <= shift_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_d[7:1] == GLOBAL_ADDR) begin
                rw_q    <= shift_d[0];
                state_q <= ST_ADDR;
              end else begin
                frame_error_q <= 1'b1;
                state_q       <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            shift_q   <= shift_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_q  <= addr_d;
              rw_q    <= wr_flag_d;
              state_q <= ST_DATA;
              if (!wr_flag_d) begin
                // Present the read MSB before the data period starts
                mdo_q      <= rd_byte_d[7];
                rd_shift_q <= rd_byte_d[6:0];
                oe_q       <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            shift_q   <= shift_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (rw_q) begin
              if (bit_cnt_q == 3'd7) begin
                if (addr_in_range(addr_q, REG_ADDR_BITS)) begin
                  reg_wr_strobe_q <= 1'b1;
                  wr_addr_q       <= addr_q;
                  wr_data_q       <= shift_d;
                end
                state_q <= ST_DONE;
              end
            end else begin
              if (bit_cnt_q == 3'd7) begin
                mdo_q   <= 1'b0;
                oe_q    <= 1'b0;
                state_q <= ST_DONE;
              end else begin
                mdo_q      <= rd_shift_q[6];
                rd_shift_q <= {rd_shift_q[5:0], 1'b0};
              end
            end
          end
          default: begin
            // IDLE, DONE and IGNORE disregard clock activity
          end
        endcase
      end
    end
  end

  // Register file takes the write the cycle after it is announced
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else if (reg_wr_strobe_q) begin
      regs_q[wr_addr_q[REG_ADDR_BITS-1:0]] <= wr_data_q;
    end
  end

  assign spi.spi_mdo    = mdo_q;
  assign spi.spi_mdo_oe = oe_q;
  assign reg_wr_strobe  = reg_wr_strobe_q;
  assign reg_wr_addr    = wr_addr_q;
  assign reg_wr_data    = wr_data_q;
  assign frame_error    = frame_error_q;
  assign peek_data      = regs_q[peek_addr];

endmodule

// File: tb/tb_spi_responder.sv
// Bench: three responders (TI, ADI, unresponsive) on one shared mclk/mdi bus
// with separate chip selects, checked against a register-level model.
`timescale 1ns/1ps
module tb_spi_responder;
  import spi_defs::*;

  localparam int HALF = 8;  // clk cycles per mclk phase

  logic clk = 1'b0;
  logic reset;
  logic mclk, mdi, cs_ti, cs_adi;
  logic [5:0] peek_addr;
  always #5 clk = ~clk;

  spi_responder_if ti_if ();
  spi_responder_if adi_if ();
  spi_responder_if none_if ();

  assign ti_if.spi_mclk   = mclk;  assign ti_if.spi_mdi   = mdi;  assign ti_if.spi_cs   = cs_ti;
  assign adi_if.spi_mclk  = mclk;  assign adi_if.spi_mdi  = mdi;  assign adi_if.spi_cs  = cs_adi;
  assign none_if.spi_mclk = mclk;  assign none_if.spi_mdi = mdi;  assign none_if.spi_cs = cs_ti;

  logic       ti_stb, adi_stb, none_stb, ti_err, adi_err, none_err;
  logic [7:0] ti_wa, ti_wd, adi_wa, adi_wd, none_wa, none_wd, ti_pk, adi_pk, none_pk;

  spi_responder #(.FORMAT(1), .GLOBAL_ADDR(7'h04), .REG_ADDR_BITS(6)) u_ti (
    .clk(clk), .reset(reset), .spi(ti_if.slave), .reg_wr_strobe(ti_stb),
    .reg_wr_addr(ti_wa), .reg_wr_data(ti_wd), .peek_addr(peek_addr),
    .peek_data(ti_pk), .frame_error(ti_err));
  spi_responder #(.FORMAT(2), .GLOBAL_ADDR(7'h04), .REG_ADDR_BITS(6)) u_adi (
    .clk(clk), .reset(reset), .spi(adi_if.slave), .reg_wr_strobe(adi_stb),
    .reg_wr_addr(adi_wa), .reg_wr_data(adi_wd), .peek_addr(peek_addr),
    .peek_data(adi_pk), .frame_error(adi_err));
  spi_responder #(.FORMAT(0), .GLOBAL_ADDR(7'h04), .REG_ADDR_BITS(6)) u_none (
    .clk(clk), .reset(reset), .spi(none_if.slave), .reg_wr_strobe(none_stb),
    .reg_wr_addr(none_wa), .reg_wr_data(none_wd), .peek_addr(peek_addr),
    .peek_data(none_pk), .frame_error(none_err));

  // Reference model: register contents, pending writes, error counts
  logic [7:0]  mem_m [2][64];
  logic [15:0] exp_wr_ti[$];
  logic [15:0] exp_wr_adi[$];
  int          err_cnt [3];
  bit          rd_window [2];
  bit          quiet;
  int          cur_dut;
  int          checks = 0, failures = 0;
  logic [7:0]  last_cap;
  int          last_err_delta;
  logic [15:0] mon_e;

  wire sel_mdo = (cur_dut == 0) ? ti_if.spi_mdo    : adi_if.spi_mdo;
  wire sel_oe  = (cur_dut == 0) ? ti_if.spi_mdo_oe : adi_if.spi_mdo_oe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Per-cycle compare of strobes, error pulses, MDO enables and peek data
  always @(negedge clk) begin
    if (reset) begin
      if (ti_stb) begin
        chk("ti_strobe_expected", 32'(exp_wr_ti.size() != 0), 32'd1);
        if (exp_wr_ti.size() != 0) begin
          mon_e = exp_wr_ti.pop_front();
          chk("ti_wr_addr", ti_wa, mon_e[15:8]);
          chk("ti_wr_data", ti_wd, mon_e[7:0]);
        end
      end
      if (adi_stb) begin
        chk("adi_strobe_expected", 32'(exp_wr_adi.size() != 0), 32'd1);
        if (exp_wr_adi.size() != 0) begin
          mon_e = exp_wr_adi.pop_front();
          chk("adi_wr_addr", adi_wa, mon_e[15:8]);
          chk("adi_wr_data", adi_wd, mon_e[7:0]);
        end
      end
      if (ti_err)  err_cnt[0]++;
      if (adi_err) err_cnt[1]++;
      chk("ti_oe_outside_read",  ti_if.spi_mdo_oe  & ~rd_window[0], 32'd0);
      chk("adi_oe_outside_read", adi_if.spi_mdo_oe & ~rd_window[1], 32'd0);
      chk("none_activity", {none_if.spi_mdo_oe, none_if.spi_mdo, none_stb, none_err}, 32'd0);
      chk("none_peek", none_pk, 32'd0);
      if (quiet) begin
        chk("ti_peek",  ti_pk,  mem_m[0][peek_addr]);
        chk("adi_peek", adi_pk, mem_m[1][peek_addr]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      peek_addr = 6'($urandom);
    end
  endtask

  // Drive one frame bit-by-bit, capture MDO during read data, check outcome
  task automatic do_frame(input int d, input logic [23:0] fr, input int nbits,
                          input int send_bits, input bit read_dec, input logic [7:0] exp_rd,
                          input int exp_err, input bit full, input bit do_reset);
    int err0;
    bit oe_ok;
    logic [7:0] cap;
    err0 = err_cnt[d]; oe_ok = 1'b1; cap = 8'h00;
    quiet = 1'b0; cur_dut = d;
    @(posedge clk); #1;
    if (d == 0) cs_ti = 1'b1; else cs_adi = 1'b1;
    wait_clk(HALF);
    for (int j = 0; j < send_bits; j++) begin
      #1;
      mclk = 1'b1;
      mdi  = (j < nbits) ? fr[23-j] : 1'($urandom);
      wait_clk(HALF); #1;
      if (read_dec && j >= nbits - 8 && j < nbits) begin
        cap = {cap[6:0], sel_mdo};
        if (sel_oe !== 1'b1) oe_ok = 1'b0;
      end
      if (read_dec && j == nbits - 9) rd_window[d] = 1'b1;
      mclk = 1'b0;
      wait_clk(HALF);
      if (read_dec && full && j == nbits - 1) begin
        #1;
        chk("oe_drop_after_data", sel_oe, 32'd0);
        rd_window[d] = 1'b0;
      end
    end
    #1;
    if (do_reset) begin
      reset = 1'b0;
      wait_clk(2); #1;
      cs_ti = 1'b0; cs_adi = 1'b0;
      for (int k = 0; k < 64; k++) begin mem_m[0][k] = 8'h00; mem_m[1][k] = 8'h00; end
      exp_wr_ti.delete(); exp_wr_adi.delete();
      rd_window[0] = 1'b0; rd_window[1] = 1'b0;
      wait_clk(2); #1;
      reset = 1'b1;
    end else begin
      if (d == 0) cs_ti = 1'b0; else cs_adi = 1'b0;
    end
    wait_clk(HALF);
    rd_window[d] = 1'b0;
    last_err_delta = err_cnt[d] - err0;
    last_cap = cap;
    if (!do_reset) chk("frame_error_count", last_err_delta, exp_err);
    if (full && read_dec) begin
      chk("read_data", cap, exp_rd);
      chk("read_oe_held", 32'(oe_ok), 32'd1);
    end
    chk("pending_writes", (d == 0) ? exp_wr_ti.size() : exp_wr_adi.size(), 32'd0);
  endtask

  // Model one transaction at register level, then play it on the bus
  task automatic run_frame(input int d, input bit wr, input logic [7:0] addr,
                           input logic [7:0] data, input logic [6:0] glob, input logic b6,
                           input int abort_at, input int extra, input bit do_reset);
    logic [23:0] fr;
    logic [7:0]  a, rd;
    int nbits, exp_err;
    bit dec_ok, in_rng, full;
    if (d == 0) begin
      fr = {~wr, b6, addr[5:0], data, 8'h00}; nbits = 16;
      a = {2'b00, addr[5:0]}; dec_ok = 1'b1;
    end else begin
      fr = {glob, wr, addr, data}; nbits = 24;
      a = addr; dec_ok = (glob == 7'h04);
    end
    in_rng  = (a < 8'd64);
    full    = (abort_at == 0) && !do_reset;
    exp_err = full ? (dec_ok ? 0 : 1) : 1;
    rd      = in_rng ? mem_m[d][a[5:0]] : 8'h00;
    if (full && dec_ok && wr && in_rng) begin
      if (d == 0) exp_wr_ti.push_back({a, data}); else exp_wr_adi.push_back({a, data});
    end
    do_frame(d, fr, nbits, full ? nbits + extra : abort_at, dec_ok && !wr, rd,
             exp_err, full, do_reset);
    if (full && dec_ok && wr && in_rng) mem_m[d][a[5:0]] = data;
    quiet = 1'b1;
  endtask

  task automatic peek_lit(input string name, input int d, input logic [5:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    peek_addr = a;
    #1;
    chk(name, (d == 0) ? ti_pk : adi_pk, exp);
  endtask

  initial begin
    reset = 1'b0; mclk = 1'b0; mdi = 1'b0; cs_ti = 1'b0; cs_adi = 1'b0;
    peek_addr = 6'd0; quiet = 1'b0; cur_dut = 0;
    for (int k = 0; k < 64; k++) begin mem_m[0][k] = 8'h00; mem_m[1][k] = 8'h00; end
    err_cnt[0] = 0; err_cnt[1] = 0; err_cnt[2] = 0;
    rd_window[0] = 1'b0; rd_window[1] = 1'b0;
    wait_clk(5); #1;
    reset = 1'b1;
    wait_clk(3); #1;
    chk("reset_ti_outputs", {ti_stb, ti_err, ti_if.spi_mdo, ti_if.spi_mdo_oe}, 32'd0);
    chk("reset_ti_wr_bus", {ti_wa, ti_wd}, 32'd0);
    chk("reset_adi_outputs", {adi_stb, adi_err, adi_if.spi_mdo, adi_if.spi_mdo_oe, adi_wa, adi_wd}, 32'd0);
    quiet = 1'b1;
    idle(4);

    // TI write then read-back of 0x15
    run_frame(0, 1'b1, 8'h15, 8'hA5, 7'h00, 1'b0, 0, 0, 1'b0);
    peek_lit("ti_peek_15_after_write", 0, 6'h15, 8'hA5);
    run_frame(0, 1'b0, 8'h15, 8'h00, 7'h00, 1'b0, 0, 0, 1'b0);
    chk("ti_read_15_literal", last_cap, 32'hA5);

    // ADI write 0x09 0x21 0x3C, read 0x08 0x21
    run_frame(1, 1'b1, 8'h21, 8'h3C, 7'h04, 1'b0, 0, 0, 1'b0);
    peek_lit("adi_peek_21_after_write", 1, 6'h21, 8'h3C);
    run_frame(1, 1'b0, 8'h21, 8'h00, 7'h04, 1'b0, 0, 0, 1'b0);
    chk("adi_read_21_literal", last_cap, 32'h3C);

    // ADI global mismatch 0x0B 0x21 0xFF
    run_frame(1, 1'b1, 8'h21, 8'hFF, 7'h05, 1'b0, 0, 0, 1'b0);
    chk("adi_mismatch_error_literal", last_err_delta, 32'd1);
    peek_lit("adi_peek_21_unchanged", 1, 6'h21, 8'h3C);

    // TI abort after 11 bits, then a clean write of 0x7E to reg 2
    run_frame(0, 1'b1, 8'h07, 8'h55, 7'h00, 1'b0, 11, 0, 1'b0);
    chk("ti_abort_error_literal", last_err_delta, 32'd1);
    peek_lit("ti_peek_07_not_written", 0, 6'h07, 8'h00);
    run_frame(0, 1'b1, 8'h02, 8'h7E, 7'h00, 1'b0, 0, 0, 1'b0);
    peek_lit("ti_peek_02_after_abort", 0, 6'h02, 8'h7E);

    // Reset during the data byte of a write to 0x03
    run_frame(0, 1'b1, 8'h03, 8'h99, 7'h00, 1'b0, 12, 0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      peek_lit("ti_peek_zero_after_reset", 0, 6'(i), 8'h00);
      peek_lit("adi_peek_zero_after_reset", 1, 6'(i), 8'h00);
    end
    run_frame(0, 1'b1, 8'h03, 8'h5A, 7'h00, 1'b0, 0, 0, 1'b0);
    peek_lit("ti_peek_03_after_reset", 0, 6'h03, 8'h5A);
    idle(4);

    // Randomized traffic on both targets
    for (int n = 0; n < 60; n++) begin
      int d, nb, ab;
      logic [7:0] a;
      logic [6:0] g;
      d  = int'($urandom_range(0, 1));
      nb = (d == 0) ? 16 : 24;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, nb - 1)) : 0;
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'b00, 6'($urandom)};
      g  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h04;
      run_frame(d, 1'($urandom), a, 8'($urandom), g, 1'($urandom), ab,
                int'($urandom_range(0, 3)), 1'b0);
      idle(int'($urandom_range(2, 8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
